lru_matrix_replacer: RTL
========================

// Module: lru_matrix_replacer
// PURPOSE
//   Parametrised multi-set, N-way true-LRU replacement engine for a set-associative cache controller.
//   Keeps one WAYS x WAYS age matrix and one valid vector per set.
//   Accepts one access per cycle (hit or miss) and returns the touched or victim way one cycle later.
//   Fills invalid ways first; supports per-way invalidation.
// PARAMETERS
//   WAYS   4               associativity; power of two, >= 2
//   SETS   16              number of sets; power of two, >= 1
//   WAY_W  $clog2(WAYS)    way index width (derived, do not override)
//   SET_W  $clog2(SETS)    set index width (derived; 1 when SETS==1)
// PORTS
//   clk             in   1      clock; all state updates on posedge
//   reset_n         in   1      asynchronous reset, active-low
//   acc_valid       in   1      access request this cycle
//   acc_set         in   SET_W  set index of access
//   acc_hit         in   1      1 = hit on acc_way; 0 = miss, allocate a victim
//   acc_way         in   WAY_W  hit way (ignored on miss)
//   inv_valid       in   1      invalidate request
//   inv_set         in   SET_W  set index of invalidate
//   inv_way         in   WAY_W  way to invalidate
//   rsp_valid       out  1      response valid, exactly 1 cycle after acc_valid
//   rsp_way         out  WAY_W  way touched (hit) or allocated (miss)
//   rsp_hit         out  1      registered copy of acc_hit
//   rsp_alloc_fail  out  1      miss could not allocate (only with LRU_LOCK_EN; otherwise tied 0)
// BEHAVIOUR
//   - Reset (async, reset_n=0): all matrices 0, all valid bits 0, rsp_valid/rsp_way/rsp_hit/rsp_alloc_fail = 0.
//     Reset mid-sequence discards any pending response.
//   - Age matrix per set: touching way w sets row w to all 1 (diagonal kept 0) and clears column w.
//     LRU way = lowest index whose row is all 0; after reset this is way 0.
//   - Hit: touch acc_way; set its valid bit; rsp_way = acc_way.
//   - Miss: victim = lowest-index invalid way if any, else LRU way. Touch the victim, set its valid bit;
//     rsp_way = victim.
//   - Victim and update logic read the state held before the edge. Back-to-back accesses to the same set
//     see the previous update, since state is registered each cycle; no stall, throughput 1 per cycle.
//   - Latency: rsp_* registered at the edge that samples acc_valid. rsp_valid=0 in any cycle following
//     acc_valid=0.
//   - Invalidate: clears the valid bit of inv_way in inv_set; the matrix is unchanged.
//   - Simultaneous access and invalidate to the same set: the access uses pre-invalidate valid bits.
//     If both target the same way, the access sets valid=1 (access wins); otherwise both updates apply.
//   - Accesses to different sets never modify each other's state.
// CONFIGURATION
//   LRU_LOCK_EN defined:
//     - Adds input lock_mask [WAYS-1:0], common to all sets; locked ways are never chosen as victims.
//     - Victim = lowest invalid unlocked way, else the oldest unlocked way (the unlocked way with the
//       fewest row bits set; lowest index on ties).
//     - If all ways are locked, a miss sets rsp_alloc_fail=1, rsp_way=0, and leaves state unchanged.
//     - Hits to locked ways update the matrix normally.
//   LRU_LOCK_EN undefined: no lock_mask port; rsp_alloc_fail is constant 0.
// STRUCTURE
//   - Package lru_pkg holds:
//     - default WAYS/SETS localparams
//     - typedefs way_idx_t, set_idx_t, age_row_t (logic [WAYS-1:0])
//     - function touch_matrix()
//   - Sub-module lru_matrix_set: one set's matrix, valid vector and victim selection.
//     Instantiated SETS times via generate; top level holds set decode and the response registers.
// TESTING (WAYS=4, SETS=4)
//   1. Reset, then misses on set 0 four cycles in a row -> rsp_way 0,1,2,3, each rsp_valid=1 one cycle
//      later, rsp_hit=0.
//   2. Full set 0; hits on ways 0,1,2,3, then a miss -> rsp_way=0. Hit 2, then a miss -> rsp_way=1.
//   3. Full set 0 (LRU way 0); heavy hit/miss traffic on set 1 -> a set-0 miss still returns rsp_way=0.
//   4. Full set 0, LRU way 0:
//      - Invalidate way 2, then a miss -> rsp_way=2.
//      - Invalidate way 3 in the same cycle as a miss on set 0 -> that miss returns the LRU way.
//      - A following miss -> rsp_way=3.
//   5. Assert reset_n=0 between clock edges mid-traffic:
//      - All outputs go 0 immediately, without waiting for a clock edge.
//      - After release, a miss on any set -> rsp_way=0.
//   6. LRU_LOCK_EN, full set 0 with LRU order 0,1,2,3:
//      - lock_mask=4'b0011, then a miss -> rsp_way=2.
//      - lock_mask=4'b1111, then a miss -> rsp_alloc_fail=1; a later unlocked miss -> rsp_way=0.

Source files
------------

// File: rtl/lru_matrix_replacer_pkg.sv
// Shared default geometry, index/row types and the age-matrix touch rule for the LRU replacer.
package lru_pkg;

   localparam int DEF_WAYS = 4;
   localparam int DEF_SETS = 16;
   localparam int DEF_WAY_W = $clog2(DEF_WAYS);
   localparam int DEF_SET_W = (DEF_SETS > 1) ? $clog2(DEF_SETS) : 1;
   // Widest row touch_matrix can handle; callers widen/truncate to their own WAYS.
   localparam int MAX_WAYS = 64;

   typedef logic [DEF_WAY_W-1:0] way_idx_t;
   typedef logic [DEF_SET_W-1:0] set_idx_t;
   typedef logic [DEF_WAYS-1:0]  age_row_t;
   typedef logic [MAX_WAYS-1:0]  wide_row_t;

   // New value of row r after touching way w: the touched row becomes all ones bar its
   // diagonal, every other row loses column w.
   function automatic wide_row_t touch_matrix(input wide_row_t row, input int r, input int w);
      wide_row_t res;
      if (r == w) begin
         res = ~(wide_row_t'(1) << r);
      end else begin
         res = row & ~(wide_row_t'(1) << w);
      end
      return res;
   endfunction

endpackage

// File: rtl/lru_matrix_replacer_if.sv
// Access/invalidate request and response bundle of lru_matrix_replacer; lock_mask exists only
// when LRU_LOCK_EN is defined.
interface lru_matrix_replacer_if #(
   parameter int WAYS = lru_pkg::DEF_WAYS,
   parameter int SETS = lru_pkg::DEF_SETS
);
   import lru_pkg::*;

   localparam int WAY_W = $clog2(WAYS);
   localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;

   logic             acc_valid;
   logic [SET_W-1:0] acc_set;
   logic             acc_hit;
   logic [WAY_W-1:0] acc_way;
   logic             inv_valid;
   logic [SET_W-1:0] inv_set;
   logic [WAY_W-1:0] inv_way;
`ifdef LRU_LOCK_EN
   logic [WAYS-1:0]  lock_mask;
`endif
   logic             rsp_valid;
   logic [WAY_W-1:0] rsp_way;
   logic             rsp_hit;
   logic             rsp_alloc_fail;

   modport master (
      output acc_valid, acc_set, acc_hit, acc_way, inv_valid, inv_set, inv_way,
`ifdef LRU_LOCK_EN
      output lock_mask,
`endif
      input  rsp_valid, rsp_way, rsp_hit, rsp_alloc_fail
   );

   modport slave (
      input  acc_valid, acc_set, acc_hit, acc_way, inv_valid, inv_set, inv_way,
`ifdef LRU_LOCK_EN
      input  lock_mask,
`endif
      output rsp_valid, rsp_way, rsp_hit, rsp_alloc_fail
   );

endinterface

// File: rtl/lru_matrix_replacer_set.sv
// One set: WAYS x WAYS age matrix, valid vector and combinational victim pick from pre-edge state.
// LRU_LOCK_EN adds lock_mask victim exclusion and an alloc_fail flag; no backpressure.
module lru_matrix_set #(
   parameter int WAYS = lru_pkg::DEF_WAYS
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    acc_en,
   input  logic                    acc_hit,
   input  logic [$clog2(WAYS)-1:0] acc_way,
   input  logic                    inv_en,
   input  logic [$clog2(WAYS)-1:0] inv_way,
`ifdef LRU_LOCK_EN
   input  logic [WAYS-1:0]         lock_mask,
   output logic                    alloc_fail,
`endif
   output logic [$clog2(WAYS)-1:0] rsp_way
);
   import lru_pkg::*;

   localparam int WAY_W = $clog2(WAYS);

   logic [WAYS-1:0]  age [WAYS];
   logic [WAYS-1:0]  valid;
   logic [WAYS-1:0]  cand;
   logic [WAYS-1:0]  free;
   logic [WAY_W-1:0] victim;
   logic [WAY_W-1:0] target;
   logic             no_victim;
   logic             touch;
`ifdef LRU_LOCK_EN
   int               best_cnt;
`endif

   always_comb begin
      victim    = '0;
      no_victim = 1'b0;
`ifdef LRU_LOCK_EN
      cand      = ~lock_mask;
      best_cnt  = WAYS + 1;
`else
      cand      = '1;
`endif
      free = ~valid & cand;
      if (|free) begin
         for (int i = WAYS - 1; i >= 0; i--) begin
            if (free[i]) victim = WAY_W'(i);
         end
      end else begin
`ifdef LRU_LOCK_EN
         // Fewer row bits means older; strict compare keeps the lowest index on ties.
         for (int i = 0; i < WAYS; i++) begin
            if (cand[i] && ($countones(age[i]) < best_cnt)) begin
               best_cnt = $countones(age[i]);
               victim   = WAY_W'(i);
            end
         end
         no_victim = ~|cand;
`else
         for (int i = WAYS - 1; i >= 0; i--) begin
            if (age[i] == '0) victim = WAY_W'(i);
         end
`endif
      end
      target  = acc_hit ? acc_way : victim;
      touch   = acc_en && (acc_hit || !no_victim);
      rsp_way = target;
   end

`ifdef LRU_LOCK_EN
   assign alloc_fail = no_victim && !acc_hit;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < WAYS; r++) begin
            age[r] <= '0;
         end
         valid <= '0;
      end else begin
         if (touch) begin
            for (int r = 0; r < WAYS; r++) begin
               age[r] <= WAYS'(touch_matrix(wide_row_t'(age[r]), r, int'(target)));
            end
         end
         if (inv_en) valid[inv_way] <= 1'b0;
         // Placed after the invalidate so a same-way access keeps the way valid.
         if (touch) valid[target] <= 1'b1;
      end
   end

endmodule

// File: rtl/lru_matrix_replacer.sv
// Multi-set true-LRU replacer: response registered one cycle after each access, 1 access/cycle,
// no backpressure. LRU_LOCK_EN adds lock_mask and a live rsp_alloc_fail.
module lru_matrix_replacer #(
   parameter int WAYS = lru_pkg::DEF_WAYS,
   parameter int SETS = lru_pkg::DEF_SETS
) (
   input  logic                  clk,
   input  logic                  reset_n,
   lru_matrix_replacer_if.slave  bus
);
   import lru_pkg::*;

   localparam int WAY_W = $clog2(WAYS);
   localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;

   logic [SETS-1:0]  acc_en;
   logic [SETS-1:0]  inv_en;
   logic [WAY_W-1:0] set_way [SETS];
   logic [WAY_W-1:0] next_way;
`ifdef LRU_LOCK_EN
   logic [SETS-1:0]  set_fail;
   logic             next_fail;
`endif

   for (genvar s = 0; s < SETS; s++) begin : g_set
      assign acc_en[s] = bus.acc_valid && (bus.acc_set == SET_W'(s));
      assign inv_en[s] = bus.inv_valid && (bus.inv_set == SET_W'(s));

      lru_matrix_set #(.WAYS(WAYS)) u_set (
         .clk        (clk),
         .reset_n    (reset_n),
         .acc_en     (acc_en[s]),
         .acc_hit    (bus.acc_hit),
         .acc_way    (bus.acc_way),
         .inv_en     (inv_en[s]),
         .inv_way    (bus.inv_way),
`ifdef LRU_LOCK_EN
         .lock_mask  (bus.lock_mask),
         .alloc_fail (set_fail[s]),
`endif
         .rsp_way    (set_way[s])
      );
   end

   // At most one set is enabled, so the mux collapses to 0 when there is no access.
   always_comb begin
      next_way  = '0;
`ifdef LRU_LOCK_EN
      next_fail = 1'b0;
`endif
      for (int s = 0; s < SETS; s++) begin
         if (acc_en[s]) begin
            next_way  = set_way[s];
`ifdef LRU_LOCK_EN
            next_fail = set_fail[s];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_way   <= '0;
         bus.rsp_hit   <= 1'b0;
      end else begin
         bus.rsp_valid <= bus.acc_valid;
         bus.rsp_way   <= next_way;
         bus.rsp_hit   <= bus.acc_valid && bus.acc_hit;
      end
   end

`ifdef LRU_LOCK_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.rsp_alloc_fail <= 1'b0;
      end else begin
         bus.rsp_alloc_fail <= bus.acc_valid && !bus.acc_hit && next_fail;
      end
   end
`else
   assign bus.rsp_alloc_fail = 1'b0;
`endif

endmodule
